uart_boot_loader: RTL and testbench

- Boot sequencer between the UART byte receiver and the instruction ROM write port inside mother_board.
- Holds the CPU in reset after power-up.
- Receives a framed program image over UART, assembles 32-bit little-endian words and writes them into ROM.
- Verifies an XOR checksum, then releases the CPU to run.

---
 rtl/uart_boot_loader_if.sv | 25 ++
 rtl/uart_boot_loader.sv | 151 +++++++++++++++
 tb/tb_uart_boot_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Bundle of the UART receive stream, the ROM write port and the loader status
// lines. The loader is the slave side; the UART/ROM/CPU environment is the master.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  rx_valid, rx_data,
        output rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, err
    );

    modport master (
        output rx_valid, rx_data,
        input  rom_we, rom_addr, rom_wdata, cpu_reset, busy, done, err
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Boot sequencer: receives a framed program image from the UART byte stream,
// writes it into instruction ROM as little-endian 32-bit words, checks the XOR
// checksum and only then releases the CPU from reset.
module uart_boot_loader #(
    parameter int         ADDR_W  = 10,
    parameter int         TIMEOUT = 1_000_000,
    parameter logic [7:0] SYNC    = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    uart_boot_loader_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, RUN} state_t;

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        csum_q, csum_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [23:0]       word_q, word_d;
    logic [15:0]       len_q, len_d;
    logic              in_frame;
    logic [15:0]       len_full;

    // Next-state, datapath updates and the inter-byte watchdog.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        csum_d   = csum_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        tcnt_d   = tcnt_q;
        word_d   = word_q;
        len_d    = len_q;
        in_frame = (state_q == LEN0) || (state_q == LEN1) ||
                   (state_q == DATA) || (state_q == CSUM);
        len_full = {bus.rx_data, len_q[7:0]};

        // Address advances the cycle after each write strobe.
        if (we_q) addr_d = addr_q + ADDR_W'(1);
        if (in_frame) tcnt_d = tcnt_q + TW'(1);

        if (bus.rx_valid) begin
            // A byte arriving in the expiry cycle wins over the timeout.
            tcnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (bus.rx_data == SYNC) begin
                        state_d = LEN0;
                        err_d   = 1'b0;
                        csum_d  = '0;
                        addr_d  = '0;
                        idx_d   = '0;
                        wcnt_d  = '0;
                    end
                end
                LEN0: begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = LEN1;
                end
                LEN1: begin
                    len_d[15:8] = bus.rx_data;
                    if ({1'b0, len_full} > 17'(2 ** ADDR_W)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (len_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    csum_d = csum_q ^ bus.rx_data;
                    idx_d  = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: word_d[7:0]   = bus.rx_data;
                        2'd1: word_d[15:8]  = bus.rx_data;
                        2'd2: word_d[23:16] = bus.rx_data;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {bus.rx_data, word_q};
                            wcnt_d  = wcnt_q + 16'd1;
                            if (wcnt_q == len_q - 16'd1) state_d = CSUM;
                        end
                    endcase
                end
                CSUM: begin
                    if (bus.rx_data == csum_q) begin
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end else if (in_frame && (tcnt_q == TW'(TIMEOUT - 1))) begin
            err_d   = 1'b1;
            state_d = IDLE;
            tcnt_d  = '0;
        end
    end

    // Control and output registers; reset drops any pending write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            csum_q  <= csum_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Word assembly and length capture; only meaningful once a frame is open.
    always_ff @(posedge clk) begin
        word_q <= word_d;
        len_q  <= len_d;
    end

    assign bus.rom_we    = we_q;
    assign bus.rom_addr  = addr_q;
    assign bus.rom_wdata = wdata_q;
    assign bus.cpu_reset = (state_q != RUN);
    assign bus.busy      = in_frame;
    assign bus.done      = (state_q == RUN);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader (ADDR_W=4, TIMEOUT=16): directed frames, expected
// ROM writes queued at stimulus time and checked by an independent monitor.
module tb_uart_boot_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cycles = 0;

    logic [35:0] sb_q[$];
    logic [7:0]  seq[$];

    uart_boot_loader_if #(.ADDR_W(4)) bus ();

    uart_boot_loader #(.ADDR_W(4), .TIMEOUT(16), .SYNC(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Global watchdog so the run always terminates.
    always @(posedge clk) begin
        cycles <= cycles + 1;
        if (cycles > 20000) begin
            $display("FAIL watchdog cycles=%0d limit=20000", cycles);
            $fatal(1, "watchdog expired");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
        sb_q.push_back({a, d});
    endtask

    // Called at a negedge; leaves at the following negedge with rx_valid low.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    initial begin
        logic [35:0] exp;
        forever begin
            @(negedge clk);
            if (bus.rom_we === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%08h expected=none",
                             bus.rom_addr, bus.rom_wdata);
                end else begin
                    exp = sb_q.pop_front();
                    if ({bus.rom_addr, bus.rom_wdata} !== exp) begin
                        errors++;
                        $display("FAIL rom_write got=%0h:%08h expected=%0h:%08h",
                                 bus.rom_addr, bus.rom_wdata, exp[35:32], exp[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [31:0] w;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_cpu_reset", bus.cpu_reset, 1);
        chk("rst_rom_we",    bus.rom_we, 0);
        chk("rst_rom_addr",  bus.rom_addr, 0);
        chk("rst_rom_wdata", bus.rom_wdata, 0);
        chk("rst_busy",      bus.busy, 0);
        chk("rst_done",      bus.done, 0);
        chk("rst_err",       bus.err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Garbage before SYNC is ignored
        seq = '{8'h00, 8'hFF, 8'h5A};
        send_seq();
        chk("garbage_busy", bus.busy, 0);
        chk("garbage_err",  bus.err, 0);

        // Normal 2-word load
        expect_wr(4'd0, 32'h54311101);
        expect_wr(4'd1, 32'h12345678);
        send_byte(8'hA5);
        chk("frame_busy", bus.busy, 1);
        seq = '{8'h02, 8'h00, 8'h01, 8'h11, 8'h31, 8'h54, 8'h78, 8'h56, 8'h34, 8'h12, 8'h7D};
        send_seq();
        chk("load_done",      bus.done, 1);
        chk("load_cpu_reset", bus.cpu_reset, 0);
        chk("load_err",       bus.err, 0);
        chk("load_busy",      bus.busy, 0);

        // Bytes in RUN are ignored
        seq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_seq();
        repeat (2) @(negedge clk);
        chk("run_done", bus.done, 1);
        chk("run_busy", bus.busy, 0);

        pulse_reset();
        chk("rst2_cpu_reset", bus.cpu_reset, 1);
        chk("rst2_done",      bus.done, 0);

        // Bad checksum: writes still happen, error raised
        expect_wr(4'd0, 32'h54311101);
        expect_wr(4'd1, 32'h12345678);
        seq = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h11, 8'h31, 8'h54, 8'h78, 8'h56, 8'h34, 8'h12, 8'h7C};
        send_seq();
        chk("badcs_err",       bus.err, 1);
        chk("badcs_done",      bus.done, 0);
        chk("badcs_cpu_reset", bus.cpu_reset, 1);
        chk("badcs_busy",      bus.busy, 0);

        // Following good frame clears err and ends in RUN
        expect_wr(4'd0, 32'h54311101);
        expect_wr(4'd1, 32'h12345678);
        send_byte(8'hA5);
        chk("sync_clears_err", bus.err, 0);
        seq = '{8'h02, 8'h00, 8'h01, 8'h11, 8'h31, 8'h54, 8'h78, 8'h56, 8'h34, 8'h12, 8'h7D};
        send_seq();
        chk("reload_done", bus.done, 1);
        chk("reload_err",  bus.err, 0);

        pulse_reset();

        // Timeout after the last byte
        seq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h11};
        send_seq();
        chk("to_err_before", bus.err, 0);
        n = 0;
        while (n <= 40 && bus.err !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_busy",   bus.busy, 0);

        // Reset on the same edge as a 4th data byte: write dropped
        seq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h11, 8'h22};
        send_seq();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h33;
        reset = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        reset = 1'b0;
        chk("midrst_cpu_reset", bus.cpu_reset, 1);
        chk("midrst_rom_we",    bus.rom_we, 0);
        chk("midrst_busy",      bus.busy, 0);
        chk("midrst_done",      bus.done, 0);
        chk("midrst_err",       bus.err, 0);
        @(negedge clk);

        // Empty load
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq();
        chk("empty_done",      bus.done, 1);
        chk("empty_cpu_reset", bus.cpu_reset, 0);

        pulse_reset();

        // LEN=17 exceeds a 16-word ROM
        seq = '{8'hA5, 8'h11, 8'h00};
        send_seq();
        chk("len17_err",  bus.err, 1);
        chk("len17_busy", bus.busy, 0);
        repeat (3) @(negedge clk);

        // LEN=16 fills the ROM exactly
        seq = '{8'hA5, 8'h10, 8'h00};
        cs = 8'h00;
        for (int wi = 0; wi < 16; wi++) begin
            w = 32'h0;
            for (int bi = 0; bi < 4; bi++) begin
                b = 8'((wi * 4 + bi) * 37 + 5);
                seq.push_back(b);
                cs = cs ^ b;
                w[bi*8 +: 8] = b;
            end
            expect_wr(4'(wi), w);
        end
        seq.push_back(cs);
        send_seq();
        chk("len16_done", bus.done, 1);
        chk("len16_err",  bus.err, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
